jtag_debug_sysclk_bridge_v2: RTL and testbench

- Parametrised system-clock half of the CPU JTAG debug module.
- Receives update-IR/update-DR strobes and scan data from the TCK-domain logic, synchronises the strobes, and captures the DR shift register into jdo.
- Issues one-cycle take_action/take_no_action pulses per IR command.
- Unlike the fixed 2-bit/38-bit predecessor, it adds:
  - per-command consumer backpressure;
  - a sticky overrun flag;
  - configurable synchroniser depth.

---
 rtl/jtag_debug_sysclk_bridge_v2.sv | 128 ++++++++++++
 tb/tb_jtag_debug_sysclk_bridge_v2.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_sysclk_bridge_v2.sv
// System-clock half of the JTAG debug bridge: strobe sync, DR capture,
// per-command action pulses with consumer backpressure and overrun flag.
module jtag_debug_sysclk_bridge_v2 #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int ACTION_BIT  = 37,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic [IR_WIDTH-1:0]      ir_in,
  input  logic [DR_WIDTH-1:0]      sr,
  input  logic [2**IR_WIDTH-1:0]   cmd_ready,
  input  logic                     clr_overrun,
  output logic [DR_WIDTH-1:0]      jdo,
  output logic [IR_WIDTH-1:0]      ir_q,
  output logic [2**IR_WIDTH-1:0]   take_action,
  output logic [2**IR_WIDTH-1:0]   take_no_action,
  output logic                     busy,
  output logic                     overrun
);

  localparam int NUM_CMD = 2**IR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic                   uir_last_q, uir_last_d;
  logic                   udr_last_q, udr_last_d;
  logic                   uir_rise, udr_rise;

  logic [IR_WIDTH-1:0]    ir_lat_q, ir_lat_d;
  logic [IR_WIDTH-1:0]    cmd_q, cmd_d;
  logic [DR_WIDTH-1:0]    jdo_q, jdo_d;
  logic [NUM_CMD-1:0]     act_q, act_d;
  logic [NUM_CMD-1:0]     nact_q, nact_d;
  logic [NUM_CMD-1:0]     cmd_hot;
  logic                   overrun_q, overrun_d;

  always_comb begin
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_last_d = uir_sync_q[SYNC_STAGES-1];
    udr_last_d = udr_sync_q[SYNC_STAGES-1];
    uir_rise   = uir_sync_q[SYNC_STAGES-1] & ~uir_last_q;
    udr_rise   = udr_sync_q[SYNC_STAGES-1] & ~udr_last_q;
  end

  // A same-cycle IR update feeds straight into the captured command
  assign ir_lat_d = uir_rise ? ir_in : ir_lat_q;
  assign cmd_hot  = NUM_CMD'(1) << cmd_q;

  always_comb begin
    state_d   = state_q;
    jdo_d     = jdo_q;
    cmd_d     = cmd_q;
    act_d     = '0;
    nact_d    = '0;
    overrun_d = overrun_q & ~clr_overrun;
    unique case (state_q)
      IDLE: begin
        if (udr_rise) begin
          jdo_d   = sr;
          cmd_d   = ir_lat_d;
          state_d = PEND;
        end
      end
      PEND: begin
        if (cmd_ready[cmd_q]) begin
          if (jdo_q[ACTION_BIT]) act_d = cmd_hot;
          else                   nact_d = cmd_hot;
          if (udr_rise) begin
            jdo_d = sr;
            cmd_d = ir_lat_d;
          end else begin
            state_d = IDLE;
          end
        end else if (udr_rise) begin
          overrun_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      uir_last_q <= 1'b0;
      udr_last_q <= 1'b0;
      ir_lat_q   <= '0;
      cmd_q      <= '0;
      jdo_q      <= '0;
      act_q      <= '0;
      nact_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      uir_sync_q <= uir_sync_d;
      udr_sync_q <= udr_sync_d;
      uir_last_q <= uir_last_d;
      udr_last_q <= udr_last_d;
      ir_lat_q   <= ir_lat_d;
      cmd_q      <= cmd_d;
      jdo_q      <= jdo_d;
      act_q      <= act_d;
      nact_q     <= nact_d;
      overrun_q  <= overrun_d;
    end
  end

  assign jdo            = jdo_q;
  assign ir_q           = ir_lat_q;
  assign take_action    = act_q;
  assign take_no_action = nact_q;
  assign busy           = (state_q == PEND);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge_v2.sv
// Directed bench for jtag_debug_sysclk_bridge_v2 (default parameters).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_jtag_debug_sysclk_bridge_v2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_uir;
  logic        vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [3:0]  cmd_ready;
  logic        clr_overrun;
  logic [37:0] jdo;
  logic [1:0]  ir_q;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        busy;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  logic [3:0] acc;
  logic       busy_low;
  int         npulse;
  logic [3:0] last_act;

  localparam logic [37:0] SR1 = 38'h20_0000_00AB;
  localparam logic [37:0] SR2 = 38'h00_1234_5678;
  localparam logic [37:0] SR3 = 38'h20_0000_0002;
  localparam logic [37:0] SRA = 38'h20_0000_000A;
  localparam logic [37:0] SRB = 38'h00_0000_000B;
  localparam logic [37:0] SRC = 38'h00_0000_00C0;
  localparam logic [37:0] SRD = 38'h20_0000_00D0;
  localparam logic [37:0] SRE = 38'h20_0000_00E0;
  localparam logic [37:0] SRF = 38'h20_0000_00F1;

  always #5 clk = ~clk;

  jtag_debug_sysclk_bridge_v2 dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .clr_overrun    (clr_overrun),
    .jdo            (jdo),
    .ir_q           (ir_q),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .busy           (busy),
    .overrun        (overrun)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    vs_uir      = 1'b0;
    vs_udr      = 1'b0;
    ir_in       = 2'd0;
    sr          = '0;
    cmd_ready   = 4'b1111;
    clr_overrun = 1'b0;
    #3;
    chk("rst_jdo", jdo, 38'h0);
    chk("rst_irq", ir_q, 2'd0);
    chk("rst_act", take_action, 4'b0000);
    chk("rst_nact", take_no_action, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    ir_in = 2'd1; vs_uir = 1'b1;
    tick(4);
    chk("b_irq", ir_q, 2'd1);
    vs_uir = 1'b0; ir_in = 2'd0;
    tick(3);
    sr = SR1; vs_udr = 1'b1;
    tick(2);
    chk("b_busy_e1", busy, 1'b0);
    tick(1);
    chk("b_jdo_e2", jdo, SR1);
    chk("b_busy_e2", busy, 1'b1);
    chk("b_act_e2", take_action, 4'b0000);
    tick(1);
    chk("b_act_e3", take_action, 4'b0010);
    chk("b_nact_e3", take_no_action, 4'b0000);
    chk("b_busy_e3", busy, 1'b0);
    tick(1);
    chk("b_act_e4", take_action, 4'b0000);
    tick(2);
    vs_udr = 1'b0;
    tick(3);
    chk("b_act_hold", take_action, 4'b0000);

    ir_in = 2'd3; vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(3);
    chk("n_irq", ir_q, 2'd3);
    sr = SR2; vs_udr = 1'b1;
    tick(3);
    chk("n_jdo", jdo, SR2);
    tick(1);
    chk("n_nact", take_no_action, 4'b1000);
    chk("n_act", take_action, 4'b0000);
    tick(1);
    chk("n_nact_end", take_no_action, 4'b0000);
    vs_udr = 1'b0;
    tick(3);

    cmd_ready = 4'b1011;
    ir_in = 2'd2; vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(3);
    sr = SR3; vs_udr = 1'b1;
    tick(3);
    chk("bp_busy", busy, 1'b1);
    vs_udr = 1'b0;
    acc = 4'b0000; busy_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      acc = acc | take_action | take_no_action;
      busy_low = busy_low | ~busy;
    end
    chk("bp_nopulse", acc, 4'b0000);
    chk("bp_busyheld", busy_low, 1'b0);
    cmd_ready = 4'b1111;
    tick(1);
    chk("bp_act", take_action, 4'b0100);
    chk("bp_busy_fall", busy, 1'b0);
    tick(3);

    cmd_ready = 4'b0000;
    sr = SRA; vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(3);
    sr = SRB; vs_udr = 1'b1;
    tick(3);
    chk("ov_jdo", jdo, SRA);
    chk("ov_set", overrun, 1'b1);
    vs_udr = 1'b0;
    tick(3);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    chk("ov_clr", overrun, 1'b0);
    vs_udr = 1'b1;
    tick(2);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    chk("ov_setwins", overrun, 1'b1);
    chk("ov_jdo2", jdo, SRA);
    vs_udr = 1'b0;
    tick(3);
    cmd_ready = 4'b1111;
    tick(1);
    chk("ov_act", take_action, 4'b0100);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    tick(2);

    cmd_ready = 4'b0000;
    sr = SRC; vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(3);
    sr = SRD; vs_udr = 1'b1;
    tick(2);
    cmd_ready = 4'b1111;
    tick(1);
    chk("bb_nact1", take_no_action, 4'b0100);
    chk("bb_jdo2", jdo, SRD);
    chk("bb_busy", busy, 1'b1);
    chk("bb_ovr", overrun, 1'b0);
    tick(1);
    chk("bb_act2", take_action, 4'b0100);
    chk("bb_busy_end", busy, 1'b0);
    vs_udr = 1'b0;
    tick(3);

    cmd_ready = 4'b0000;
    sr = SRE; vs_udr = 1'b1;
    tick(3);
    chk("r_busy_pre", busy, 1'b1);
    vs_udr = 1'b0;
    tick(3);
    reset_n = 1'b0;
    #1;
    chk("r_busy", busy, 1'b0);
    chk("r_jdo", jdo, 38'h0);
    chk("r_irq", ir_q, 2'd0);
    cmd_ready = 4'b1111;
    tick(2);
    reset_n = 1'b1;
    acc = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      acc = acc | take_action | take_no_action;
    end
    chk("r_nopulse", acc, 4'b0000);
    chk("r_idle", busy, 1'b0);

    reset_n = 1'b0;
    sr = SRF; vs_udr = 1'b1;
    tick(3);
    reset_n = 1'b1;
    npulse = 0; last_act = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if ((take_action | take_no_action) != 4'b0000) begin
        npulse++;
        last_act = take_action;
      end
    end
    chk("rh_count", npulse, 1);
    chk("rh_act", last_act, 4'b0001);
    chk("rh_jdo", jdo, SRF);
    chk("rh_busy", busy, 1'b0);
    vs_udr = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
